// File: rtl/cmp_sweep_checker.sv
// cmp_sweep_checker: scores a fixed-length sweep of 2-input comparator results.
// Each accepted sample is checked against a locally recomputed {a>b, a==b, a<b}.
// The sample's statistics update outcome, mismatch and one-hot-violation counters.
// Results are held after the final sample until the next start.
module cmp_sweep_checker #(
  parameter int WIDTH   = 2,
  parameter int SAMPLES = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             gt,
  input  logic             eq,
  input  logic             lt,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] mism_cnt,
  output logic             onehot_err
);

  localparam int               IDX_W    = $clog2(SAMPLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;

  logic [2:0] flags_p0;
  logic [2:0] exp_p0;
  logic       vld_p0;
  logic       mism_p0;
  logic       bad_p0;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic en);
    if (en && (c != CNT_MAX)) return c + CNT_W'(1);
    return c;
  endfunction

  // True when exactly one of the three flags is set.
  function automatic logic is_onehot(input logic [2:0] f);
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction

  // Stage 0: decode the incoming sample; operands compare as unsigned.
  always_comb begin
    flags_p0 = {gt, eq, lt};
    exp_p0   = {(a > b), (a == b), (a < b)};
    vld_p0   = (state == COLLECT) && in_valid;
    mism_p0  = (flags_p0 != exp_p0);
    bad_p0   = !is_onehot(flags_p0);
  end

  // Stage 1: sweep FSM with registered status and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      gt_cnt     <= '0;
      eq_cnt     <= '0;
      lt_cnt     <= '0;
      mism_cnt   <= '0;
      onehot_err <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A sample coinciding with start is dropped; collection begins next cycle.
          if (start) begin
            state      <= COLLECT;
            idx        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            gt_cnt     <= '0;
            eq_cnt     <= '0;
            lt_cnt     <= '0;
            mism_cnt   <= '0;
            onehot_err <= 1'b0;
          end
        end
        COLLECT: begin
          if (vld_p0) begin
            gt_cnt     <= sat_inc(gt_cnt, gt);
            eq_cnt     <= sat_inc(eq_cnt, eq);
            lt_cnt     <= sat_inc(lt_cnt, lt);
            mism_cnt   <= sat_inc(mism_cnt, mism_p0);
            onehot_err <= onehot_err | bad_p0;
            idx        <= idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Testbench for cmp_sweep_checker: a default instance plus a narrow-counter
// instance sharing the same stimulus, scored against a sample-list model.
module tb_cmp_sweep_checker;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [1:0] a;
  logic [1:0] b;
  logic       gt;
  logic       eq;
  logic       lt;

  logic       busy, done, onehot_err;
  logic [7:0] gt_cnt, eq_cnt, lt_cnt, mism_cnt;

  logic       s_busy, s_done, s_onehot_err;
  logic [2:0] s_gt_cnt, s_eq_cnt, s_lt_cnt, s_mism_cnt;

  int tests = 0;
  int fails = 0;

  logic [1:0] qa [N];
  logic [1:0] qb [N];
  logic [2:0] qf [N];

  always #5 clk = ~clk;

  cmp_sweep_checker #(.WIDTH(2), .SAMPLES(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .gt(gt), .eq(eq), .lt(lt),
    .busy(busy), .done(done), .gt_cnt(gt_cnt), .eq_cnt(eq_cnt),
    .lt_cnt(lt_cnt), .mism_cnt(mism_cnt), .onehot_err(onehot_err)
  );

  cmp_sweep_checker #(.WIDTH(2), .SAMPLES(N), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .gt(gt), .eq(eq), .lt(lt),
    .busy(s_busy), .done(s_done), .gt_cnt(s_gt_cnt), .eq_cnt(s_eq_cnt),
    .lt_cnt(s_lt_cnt), .mism_cnt(s_mism_cnt), .onehot_err(s_onehot_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start    = 1'b0;
    in_valid = 1'b0;
    a        = 2'd0;
    b        = 2'd0;
    {gt, eq, lt} = 3'b000;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
  endtask

  // Correct comparator answer for an operand pair.
  function automatic logic [2:0] ref_flags(input logic [1:0] x, input logic [1:0] y);
    return {x > y, x == y, x < y};
  endfunction

  // Statistic over the recorded sweep: 0=gt 1=eq 2=lt 3=mismatch, clipped at maxv.
  function automatic int model(input int which, input int maxv);
    int n = 0;
    for (int i = 0; i < N; i++) begin
      case (which)
        0:       n += int'(qf[i][2]);
        1:       n += int'(qf[i][1]);
        2:       n += int'(qf[i][0]);
        default: n += (qf[i] != ref_flags(qa[i], qb[i])) ? 1 : 0;
      endcase
    end
    return (n > maxv) ? maxv : n;
  endfunction

  function automatic logic model_oh();
    logic e = 1'b0;
    for (int i = 0; i < N; i++)
      if ($countones(qf[i]) != 1) e = 1'b1;
    return e;
  endfunction

  task automatic fill_exhaustive();
    for (int i = 0; i < N; i++) begin
      qa[i] = 2'(i / 4);
      qb[i] = 2'(i % 4);
      qf[i] = ref_flags(qa[i], qb[i]);
    end
  endtask

  // Start a sweep and feed the N recorded samples.
  // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
  task automatic run_sweep(input int gap_mode, input bit start_valid, input bit mid_start,
                           output bit busy_seen, output int cyc, output bit timeout);
    int idx;
    bit v;
    start = 1'b1;
    if (start_valid) begin
      in_valid = 1'b1;
      a = 2'd3;
      b = 2'd0;
      {gt, eq, lt} = 3'b111;
    end
    step();
    start     = 1'b0;
    in_valid  = 1'b0;
    busy_seen = busy;
    idx = 0;
    cyc = 0;
    while (idx < N && cyc < 400) begin
      if (gap_mode == 0)      v = 1'b1;
      else if (gap_mode == 1) v = (cyc % 2 == 0);
      else                    v = ($urandom % 3 != 0);
      in_valid = v;
      a = qa[idx];
      b = qb[idx];
      {gt, eq, lt} = qf[idx];
      start = mid_start && (idx == 8) && v;
      step();
      cyc++;
      if (v) idx++;
    end
    idle_inputs();
    timeout = (idx < N);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    tests++;
    if ({busy, done, onehot_err} !== 3'b000) begin
      fails++;
      $display("FAIL reset_status: got busy/done/oh=%b required 000", {busy, done, onehot_err});
    end
    tests++;
    if ({gt_cnt, eq_cnt, lt_cnt, mism_cnt} !== 32'h0) begin
      fails++;
      $display("FAIL reset_counters: got %h required 0", {gt_cnt, eq_cnt, lt_cnt, mism_cnt});
    end
    rst = 1'b0;
    step();
    // Samples offered in IDLE are ignored.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 2'd3;
      b = 2'd1;
      {gt, eq, lt} = 3'b011;
      step();
    end
    idle_inputs();
    tests++;
    if ({busy, gt_cnt, eq_cnt, lt_cnt, mism_cnt, onehot_err} !== 34'h0) begin
      fails++;
      $display("FAIL idle_ignores_valid: got busy=%b cnts=%h oh=%b required all 0",
               busy, {gt_cnt, eq_cnt, lt_cnt, mism_cnt}, onehot_err);
    end
  endtask

  task automatic test_exhaustive();
    bit bs, to;
    int cyc;
    logic [31:0] hold;
    fill_exhaustive();
    run_sweep(0, 1'b0, 1'b0, bs, cyc, to);
    tests++;
    if (bs !== 1'b1) begin
      fails++;
      $display("FAIL exh_busy_rise: got %b required 1", bs);
    end
    tests++;
    if (to || cyc != N || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL exh_done_timing: got cyc=%0d done=%b busy=%b required cyc=%0d done=1 busy=0",
               cyc, done, busy, N);
    end
    tests++;
    if (gt_cnt !== 8'(model(0, 255))) begin
      fails++;
      $display("FAIL exh_gt_cnt: got %0d required %0d", gt_cnt, model(0, 255));
    end
    tests++;
    if (eq_cnt !== 8'(model(1, 255))) begin
      fails++;
      $display("FAIL exh_eq_cnt: got %0d required %0d", eq_cnt, model(1, 255));
    end
    tests++;
    if (lt_cnt !== 8'(model(2, 255))) begin
      fails++;
      $display("FAIL exh_lt_cnt: got %0d required %0d", lt_cnt, model(2, 255));
    end
    tests++;
    if (mism_cnt !== 8'(model(3, 255)) || onehot_err !== model_oh()) begin
      fails++;
      $display("FAIL exh_mism_oh: got mism=%0d oh=%b required mism=%0d oh=%b",
               mism_cnt, onehot_err, model(3, 255), model_oh());
    end
    // Results hold in DONE even while samples keep arriving.
    hold = {gt_cnt, eq_cnt, lt_cnt, mism_cnt};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = 2'd1;
      b = 2'd2;
      {gt, eq, lt} = 3'b110;
      step();
    end
    idle_inputs();
    tests++;
    if ({gt_cnt, eq_cnt, lt_cnt, mism_cnt} !== hold || done !== 1'b1 || onehot_err !== 1'b0) begin
      fails++;
      $display("FAIL done_hold: got %h done=%b oh=%b required %h done=1 oh=0",
               {gt_cnt, eq_cnt, lt_cnt, mism_cnt}, done, onehot_err, hold);
    end
  endtask

  task automatic test_injected_fault();
    bit bs, to;
    int cyc;
    fill_exhaustive();
    qf[3 * 4 + 1] = 3'b001;
    run_sweep(0, 1'b0, 1'b0, bs, cyc, to);
    tests++;
    if (to || done !== 1'b1 ||
        {gt_cnt, eq_cnt, lt_cnt, mism_cnt, onehot_err} !==
        {8'(model(0, 255)), 8'(model(1, 255)), 8'(model(2, 255)), 8'(model(3, 255)), model_oh()}) begin
      fails++;
      $display("FAIL fault_stats: got gt=%0d eq=%0d lt=%0d mism=%0d oh=%b done=%b required %0d %0d %0d %0d %b",
               gt_cnt, eq_cnt, lt_cnt, mism_cnt, onehot_err, done,
               model(0, 255), model(1, 255), model(2, 255), model(3, 255), model_oh());
    end
  endtask

  task automatic test_non_onehot();
    bit bs, to;
    int cyc;
    fill_exhaustive();
    qf[2 * 4 + 2] = 3'b110;
    run_sweep(0, 1'b0, 1'b0, bs, cyc, to);
    tests++;
    if (to || {gt_cnt, eq_cnt, lt_cnt, mism_cnt} !==
        {8'(model(0, 255)), 8'(model(1, 255)), 8'(model(2, 255)), 8'(model(3, 255))}) begin
      fails++;
      $display("FAIL nonoh_counts: got gt=%0d eq=%0d lt=%0d mism=%0d required %0d %0d %0d %0d",
               gt_cnt, eq_cnt, lt_cnt, mism_cnt,
               model(0, 255), model(1, 255), model(2, 255), model(3, 255));
    end
    tests++;
    if (onehot_err !== model_oh()) begin
      fails++;
      $display("FAIL nonoh_flag: got %b required %b", onehot_err, model_oh());
    end
    // A new start wipes everything.
    start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if ({gt_cnt, eq_cnt, lt_cnt, mism_cnt, onehot_err} !== 33'h0 || busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL restart_clear: got cnts=%h oh=%b busy=%b done=%b required 0 0 1 0",
               {gt_cnt, eq_cnt, lt_cnt, mism_cnt}, onehot_err, busy, done);
    end
    pulse_reset();
  endtask

  task automatic test_gaps_saturation();
    bit bs, to;
    int cyc;
    for (int i = 0; i < N; i++) begin
      qa[i] = 2'($urandom);
      qb[i] = qa[i];
      qf[i] = 3'b010;
    end
    run_sweep(1, 1'b0, 1'b0, bs, cyc, to);
    tests++;
    if (to || cyc != 2 * N - 1 || s_done !== 1'b1 || done !== 1'b1) begin
      fails++;
      $display("FAIL gap_timing: got cyc=%0d s_done=%b done=%b required cyc=%0d both done",
               cyc, s_done, done, 2 * N - 1);
    end
    tests++;
    if (s_eq_cnt !== 3'(model(1, 7))) begin
      fails++;
      $display("FAIL sat_eq_cnt: got %0d required %0d", s_eq_cnt, model(1, 7));
    end
    tests++;
    if ({s_gt_cnt, s_lt_cnt, s_mism_cnt, s_onehot_err} !== 10'h0 || eq_cnt !== 8'(model(1, 255))) begin
      fails++;
      $display("FAIL sat_others: got s_gt=%0d s_lt=%0d s_mism=%0d s_oh=%b eq=%0d required 0 0 0 0 %0d",
               s_gt_cnt, s_lt_cnt, s_mism_cnt, s_onehot_err, eq_cnt, model(1, 255));
    end
  endtask

  task automatic test_start_collisions();
    bit bs, to;
    int cyc;
    pulse_reset();
    fill_exhaustive();
    run_sweep(0, 1'b1, 1'b1, bs, cyc, to);
    tests++;
    if (to || cyc != N || done !== 1'b1) begin
      fails++;
      $display("FAIL collide_timing: got cyc=%0d done=%b required cyc=%0d done=1", cyc, done, N);
    end
    tests++;
    if ({gt_cnt, eq_cnt, lt_cnt, mism_cnt, onehot_err} !==
        {8'(model(0, 255)), 8'(model(1, 255)), 8'(model(2, 255)), 8'(model(3, 255)), model_oh()}) begin
      fails++;
      $display("FAIL collide_stats: got gt=%0d eq=%0d lt=%0d mism=%0d oh=%b required %0d %0d %0d %0d %b",
               gt_cnt, eq_cnt, lt_cnt, mism_cnt, onehot_err,
               model(0, 255), model(1, 255), model(2, 255), model(3, 255), model_oh());
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit bs, to;
    int cyc;
    fill_exhaustive();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = qa[i];
      b = qb[i];
      {gt, eq, lt} = qf[i];
      step();
    end
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, gt_cnt, eq_cnt, lt_cnt, mism_cnt, onehot_err} !== 35'h0 ||
        {s_busy, s_eq_cnt} !== 4'h0) begin
      fails++;
      $display("FAIL async_reset: got busy=%b done=%b cnts=%h oh=%b s_busy=%b required all 0",
               busy, done, {gt_cnt, eq_cnt, lt_cnt, mism_cnt}, onehot_err, s_busy);
    end
    #2;
    rst = 1'b0;
    step();
    run_sweep(0, 1'b0, 1'b0, bs, cyc, to);
    tests++;
    if (to || done !== 1'b1 ||
        {gt_cnt, eq_cnt, lt_cnt, mism_cnt, onehot_err} !==
        {8'(model(0, 255)), 8'(model(1, 255)), 8'(model(2, 255)), 8'(model(3, 255)), model_oh()}) begin
      fails++;
      $display("FAIL after_reset_sweep: got gt=%0d eq=%0d lt=%0d mism=%0d oh=%b done=%b required %0d %0d %0d %0d %b",
               gt_cnt, eq_cnt, lt_cnt, mism_cnt, onehot_err, done,
               model(0, 255), model(1, 255), model(2, 255), model(3, 255), model_oh());
    end
  endtask

  task automatic test_random();
    bit bs, to;
    int cyc;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++) begin
        qa[i] = 2'($urandom);
        qb[i] = 2'($urandom);
        qf[i] = ($urandom % 4 == 0) ? 3'($urandom) : ref_flags(qa[i], qb[i]);
      end
      run_sweep(2, 1'($urandom), 1'($urandom), bs, cyc, to);
      tests++;
      if (to || done !== 1'b1 ||
          {gt_cnt, eq_cnt, lt_cnt, mism_cnt, onehot_err} !==
          {8'(model(0, 255)), 8'(model(1, 255)), 8'(model(2, 255)), 8'(model(3, 255)), model_oh()}) begin
        fails++;
        $display("FAIL rand_%0d: got gt=%0d eq=%0d lt=%0d mism=%0d oh=%b done=%b required %0d %0d %0d %0d %b",
                 it, gt_cnt, eq_cnt, lt_cnt, mism_cnt, onehot_err, done,
                 model(0, 255), model(1, 255), model(2, 255), model(3, 255), model_oh());
      end
      tests++;
      if ({s_gt_cnt, s_eq_cnt, s_lt_cnt, s_mism_cnt, s_onehot_err} !==
          {3'(model(0, 7)), 3'(model(1, 7)), 3'(model(2, 7)), 3'(model(3, 7)), model_oh()}) begin
        fails++;
        $display("FAIL rand_sat_%0d: got gt=%0d eq=%0d lt=%0d mism=%0d oh=%b required %0d %0d %0d %0d %b",
                 it, s_gt_cnt, s_eq_cnt, s_lt_cnt, s_mism_cnt, s_onehot_err,
                 model(0, 7), model(1, 7), model(2, 7), model(3, 7), model_oh());
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_exhaustive();
    test_injected_fault();
    test_non_onehot();
    test_gaps_saturation();
    test_start_collisions();
    test_reset_mid_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
